// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared field widths, limits and mode encoding for the time-of-day keeper
package clock_pkg;

  localparam int HOURS_W   = 5;
  localparam int MIN_W     = 6;
  localparam int SEC_W     = 6;
  localparam int MAX_HOURS = 23;
  localparam int MAX_MIN   = 59;
  localparam int MAX_SEC   = 59;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_SET_H = 2'd1,
    MODE_SET_M = 2'd2
  } mode_e;

  // Set-hours wins when both buttons are held.
  function automatic mode_e decode_mode(input logic set_hours, input logic set_minutes);
    if (set_hours) begin
      return MODE_SET_H;
    end
    if (set_minutes) begin
      return MODE_SET_M;
    end
    return MODE_RUN;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - modulo-(MAX+1) field counter with clear and combinational carry-out
module wrap_counter #(
  parameter int WIDTH = 6,
  parameter int MAX   = 59
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] reset_val,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value,
  output logic             carry
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;
  logic             at_max;

  assign at_max = (value_q == MAX_V);

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      value_d = at_max ? '0 : value_q + ONE_V;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= reset_val;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign carry = inc & at_max;

endmodule

// File: rtl/clock_time_register.sv
// rtl/clock_time_register.sv - 24h time-of-day register with 1 Hz advance and button fast-set
module clock_time_register
  import clock_pkg::*;
#(
  parameter int unsigned RESET_HOURS   = 0,
  parameter int unsigned RESET_MINUTES = 0,
  parameter int unsigned RESET_SECONDS = 0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_en,
  input  logic               i_1hz_stb,
  input  logic               i_fast_set_stb,
  input  logic               i_set_hours,
  input  logic               i_set_minutes,
  output logic [HOURS_W-1:0] o_hours,
  output logic [MIN_W-1:0]   o_minutes,
  output logic [SEC_W-1:0]   o_seconds,
  output logic               o_day_stb
);

  if (RESET_HOURS > MAX_HOURS || RESET_MINUTES > MAX_MIN || RESET_SECONDS > MAX_SEC) begin : g_bad_reset
    $error("clock_time_register: reset time out of range");
  end

  mode_e mode;
  logic  run, set_h, set_m;
  logic  sec_inc, sec_clr, sec_carry;
  logic  min_inc, min_carry;
  logic  hr_inc, hr_carry;
  logic  day_d, day_q;

  assign mode  = decode_mode(i_set_hours, i_set_minutes);
  assign run   = i_en & (mode == MODE_RUN);
  assign set_h = i_en & (mode == MODE_SET_H);
  assign set_m = i_en & (mode == MODE_SET_M);

  // Carries ripple only while running; set-mode wraps stay inside their own field.
  assign sec_inc = run & i_1hz_stb;
  assign sec_clr = set_m;
  assign min_inc = run ? sec_carry : (set_m & i_fast_set_stb);
  assign hr_inc  = run ? min_carry : (set_h & i_fast_set_stb);
  assign day_d   = run & hr_carry;

  wrap_counter #(.WIDTH(SEC_W), .MAX(MAX_SEC)) u_sec (
    .clk       (i_clk),
    .reset     (i_reset),
    .reset_val (SEC_W'(RESET_SECONDS)),
    .inc       (sec_inc),
    .clr       (sec_clr),
    .value     (o_seconds),
    .carry     (sec_carry)
  );

  wrap_counter #(.WIDTH(MIN_W), .MAX(MAX_MIN)) u_min (
    .clk       (i_clk),
    .reset     (i_reset),
    .reset_val (MIN_W'(RESET_MINUTES)),
    .inc       (min_inc),
    .clr       (1'b0),
    .value     (o_minutes),
    .carry     (min_carry)
  );

  wrap_counter #(.WIDTH(HOURS_W), .MAX(MAX_HOURS)) u_hr (
    .clk       (i_clk),
    .reset     (i_reset),
    .reset_val (HOURS_W'(RESET_HOURS)),
    .inc       (hr_inc),
    .clr       (1'b0),
    .value     (o_hours),
    .carry     (hr_carry)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      day_q <= 1'b0;
    end else begin
      day_q <= day_d;
    end
  end

  assign o_day_stb = day_q;

endmodule

// File: tb/tb_clock_time_register.sv
// tb/tb_clock_time_register.sv - scoreboard bench for clock_time_register
module tb_clock_time_register;

  logic       clk;
  logic       i_reset, i_en, i_1hz_stb, i_fast_set_stb, i_set_hours, i_set_minutes;
  logic [4:0] o_hours;
  logic [5:0] o_minutes, o_seconds;
  logic       o_day_stb;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       d;
  } exp_t;

  exp_t sb[$];

  clock_time_register dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_en           (i_en),
    .i_1hz_stb      (i_1hz_stb),
    .i_fast_set_stb (i_fast_set_stb),
    .i_set_hours    (i_set_hours),
    .i_set_minutes  (i_set_minutes),
    .o_hours        (o_hours),
    .o_minutes      (o_minutes),
    .o_seconds      (o_seconds),
    .o_day_stb      (o_day_stb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d, required 0", sb.size());
    $fatal(1, "watchdog");
  end

  // Monitor: the registered outputs are valid every cycle, so one expectation is popped per cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({o_hours, o_minutes, o_seconds, o_day_stb} !== {e.h, e.m, e.s, e.d}) begin
        n_fail++;
        $display("FAIL %s: got %0d:%0d:%0d day=%0b, required %0d:%0d:%0d day=%0b",
                 e.name, o_hours, o_minutes, o_seconds, o_day_stb, e.h, e.m, e.s, e.d);
      end
    end
  end

  task automatic step(input logic rst, input logic en, input logic tick, input logic fast,
                      input logic sh, input logic sm, input string nm,
                      input int eh, input int em, input int es, input logic ed);
    exp_t e;
    i_reset        = rst;
    i_en           = en;
    i_1hz_stb      = tick;
    i_fast_set_stb = fast;
    i_set_hours    = sh;
    i_set_minutes  = sm;
    @(posedge clk);
    e.name = nm;
    e.h    = 5'(eh);
    e.m    = 6'(em);
    e.s    = 6'(es);
    e.d    = ed;
    sb.push_back(e);
    #1;
  endtask

  task automatic tick(input string nm, input int eh, input int em, input int es, input logic ed);
    step(0, 1, 1, 0, 0, 0, nm, eh, em, es, ed);
  endtask

  task automatic idle(input string nm, input int eh, input int em, input int es);
    step(0, 1, 0, 0, 0, 0, nm, eh, em, es, 0);
  endtask

  initial begin
    i_reset = 1'b1; i_en = 1'b0; i_1hz_stb = 1'b0;
    i_fast_set_stb = 1'b0; i_set_hours = 1'b0; i_set_minutes = 1'b0;

    // 1. reset state, then reset mid-count at 12:34:56
    step(1, 1, 1, 1, 1, 0, "reset", 0, 0, 0, 0);
    idle("post_reset", 0, 0, 0);
    for (int i = 1; i <= 12; i++) step(0, 1, 0, 1, 1, 0, "set_h_to_12", i, 0, 0, 0);
    for (int i = 1; i <= 34; i++) step(0, 1, 0, 1, 0, 1, "set_m_to_34", 12, i, 0, 0);
    for (int i = 1; i <= 56; i++) tick("run_to_56", 12, 34, i, 0);
    step(1, 1, 1, 0, 0, 0, "reset_mid", 0, 0, 0, 0);

    // 2. seconds/minute carry, then full day rollover
    for (int i = 1; i <= 58; i++) tick("run_to_58", 0, 0, i, 0);
    tick("tick_59", 0, 0, 59, 0);
    tick("carry_min", 0, 1, 0, 0);
    for (int i = 1; i <= 23; i++) step(0, 1, 0, 1, 1, 0, "set_h_to_23", i, 1, 0, 0);
    for (int i = 2; i <= 59; i++) step(0, 1, 0, 1, 0, 1, "set_m_to_59", 23, i, 0, 0);
    for (int i = 1; i <= 59; i++) tick("run_to_235959", 23, 59, i, 0);
    tick("day_roll", 0, 0, 0, 1);
    idle("day_pulse_end", 0, 0, 0);

    // 3. set hours at 22:10:30 with interleaved 1 Hz ticks
    for (int i = 1; i <= 22; i++) step(0, 1, 0, 1, 1, 0, "set_h_to_22", i, 0, 0, 0);
    for (int i = 1; i <= 10; i++) step(0, 1, 0, 1, 0, 1, "set_m_to_10", 22, i, 0, 0);
    for (int i = 1; i <= 30; i++) tick("run_to_30", 22, 10, i, 0);
    step(0, 1, 0, 1, 1, 0, "set_h_23",      23, 10, 30, 0);
    step(0, 1, 1, 0, 1, 0, "set_h_tick_ign", 23, 10, 30, 0);
    step(0, 1, 0, 1, 1, 0, "set_h_wrap",     0, 10, 30, 0);
    step(0, 1, 1, 0, 1, 0, "set_h_tick_ign2", 0, 10, 30, 0);
    step(0, 1, 0, 1, 1, 0, "set_h_01",       1, 10, 30, 0);
    idle("set_h_release", 1, 10, 30);

    // 4. set minutes at 05:58:42
    for (int i = 1; i <= 4; i++) step(0, 1, 0, 1, 1, 0, "set_h_to_5", 1 + i, 10, 30, 0);
    for (int i = 1; i <= 48; i++) step(0, 1, 0, 1, 0, 1, "set_m_to_58", 5, 10 + i, 0, 0);
    for (int i = 1; i <= 42; i++) tick("run_to_42", 5, 58, i, 0);
    step(0, 1, 0, 0, 0, 1, "sec_clear",         5, 58, 0, 0);
    step(0, 1, 0, 1, 0, 1, "set_m_59",          5, 59, 0, 0);
    step(0, 1, 0, 1, 0, 1, "min_wrap_no_carry", 5, 0, 0, 0);
    step(0, 1, 1, 0, 0, 1, "set_m_tick_ign",    5, 0, 0, 0);

    // 5. both held, coincident set rise and tick, resume
    for (int i = 1; i <= 22; i++) step(0, 1, 0, 1, 1, 0, "set_h_to_3", (5 + i) % 24, 0, 0, 0);
    for (int i = 1; i <= 20; i++) step(0, 1, 0, 1, 0, 1, "set_m_to_20", 3, i, 0, 0);
    idle("idle_032000", 3, 20, 0);
    step(0, 1, 0, 1, 1, 1, "both_held", 4, 20, 0, 0);
    idle("both_release", 4, 20, 0);
    tick("run_042001", 4, 20, 1, 0);
    step(0, 1, 1, 0, 1, 0, "rise_drop", 4, 20, 1, 0);
    idle("rise_release", 4, 20, 1);
    tick("resume", 4, 20, 2, 0);
    idle("no_catch_up", 4, 20, 2);

    // 6. global enable freeze at 10:00:00
    for (int i = 1; i <= 6; i++) step(0, 1, 0, 1, 1, 0, "set_h_to_10", 4 + i, 20, 2, 0);
    for (int i = 1; i <= 40; i++) step(0, 1, 0, 1, 0, 1, "set_m_to_00", 10, (20 + i) % 60, 0, 0);
    idle("idle_100000", 10, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0, "en_hold", 10, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, "en_hold_set_h", 10, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, "en_hold_set_m", 10, 0, 0, 0);
    tick("en_resume", 10, 0, 1, 0);
    step(1, 0, 1, 0, 0, 0, "reset_over_en", 0, 0, 0, 0);

    i_reset = 1'b0; i_en = 1'b0; i_1hz_stb = 1'b0;
    i_fast_set_stb = 1'b0; i_set_hours = 1'b0; i_set_minutes = 1'b0;
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
